// File: rtl/load_store_unit_pkg.sv
// HighLevelControl: shared control encodings for the pipelined RISC-V core.
// Holds the load/store truncation selector, the LSU state type and the
// default datapath width.
package HighLevelControl;

`ifdef BIT_COUNT_64
    localparam int DEFAULT_BIT_COUNT = 64;
`else
    localparam int DEFAULT_BIT_COUNT = 32;
`endif

    // Access size and signedness; values follow the RISC-V load funct3 field.
    typedef enum logic [2:0] {
        BYTE               = 3'd0,
        HALF_WORD          = 3'd1,
        WORD               = 3'd2,
        NO_TRUNC           = 3'd3,
        BYTE_UNSIGNED      = 3'd4,
        HALF_WORD_UNSIGNED = 3'd5,
        WORD_UNSIGNED      = 3'd6
    } truncSrc;

    typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_RESP} lsuState;

    // log2 of the access size in bytes; NO_TRUNC (and the unused code)
    // report a doubleword and are clamped to the datapath width by the caller.
    function automatic logic [1:0] access_log2(input logic [2:0] trunc);
        logic [1:0] result;
        case (trunc)
            BYTE, BYTE_UNSIGNED:           result = 2'd0;
            HALF_WORD, HALF_WORD_UNSIGNED: result = 2'd1;
            WORD, WORD_UNSIGNED:           result = 2'd2;
            default:                       result = 2'd3;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// load_extender: moves the addressed lane of a memory read word down to
// bit 0 and sign- or zero-extends it. Purely combinational so it can also
// sit on a cache bypass path.
module load_extender
    import HighLevelControl::*;
#(
    parameter int BIT_COUNT = DEFAULT_BIT_COUNT,
    parameter int OFFSET_W  = $clog2(BIT_COUNT / 8)
) (
    input  logic [BIT_COUNT-1:0] rdata,
    input  logic [OFFSET_W-1:0]  offset,
    input  logic [2:0]           trunc,
    output logic [BIT_COUNT-1:0] extended
);

    logic [BIT_COUNT-1:0] lane;

    // Shift the selected bytes to the bottom, then extend by access type.
    always_comb begin
        lane     = rdata >> {offset, 3'b000};
        extended = lane;
        case (trunc)
            BYTE:               extended = BIT_COUNT'($signed(lane[7:0]));
            HALF_WORD:          extended = BIT_COUNT'($signed(lane[15:0]));
            WORD:               extended = BIT_COUNT'($signed(lane[31:0]));
            BYTE_UNSIGNED:      extended = BIT_COUNT'(lane[7:0]);
            HALF_WORD_UNSIGNED: extended = BIT_COUNT'(lane[15:0]);
            WORD_UNSIGNED:      extended = BIT_COUNT'(lane[31:0]);
            default:            extended = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit. Accepts one aligned access
// from the pipeline, runs a req/ready handshake with data memory, lane-shifts
// store data and strobes, extends load data, and stalls the pipeline until
// the access completes.
module load_store_unit
    import HighLevelControl::*;
#(
    parameter int BIT_COUNT = DEFAULT_BIT_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   isLoad,
    input  logic                   isStore,
    input  logic [BIT_COUNT-1:0]   addr,
    input  logic [BIT_COUNT-1:0]   storeData,
    input  logic [2:0]             trunc,
    output logic                   stall,
    output logic [BIT_COUNT-1:0]   loadResult,
    output logic                   resultValid,
    output logic                   misaligned,
    output logic                   memReq,
    output logic                   memWe,
    output logic [BIT_COUNT-1:0]   memAddr,
    output logic [BIT_COUNT-1:0]   memWdata,
    output logic [BIT_COUNT/8-1:0] memWstrb,
    input  logic                   memReady,
    input  logic [BIT_COUNT-1:0]   memRdata
);

    localparam int STRB_W   = BIT_COUNT / 8;
    localparam int OFFSET_W = $clog2(STRB_W);

    lsuState               state;
    lsuState               state_next;
    logic [OFFSET_W-1:0]   offset;
    logic [OFFSET_W-1:0]   offset_q;
    logic [2:0]            trunc_q;
    logic                  is_store_q;
    logic [1:0]            size_log2;
    logic [3:0]            size_bytes;
    logic [OFFSET_W-1:0]   align_mask;
    logic [STRB_W-1:0]     strb_base;
    logic                  access_req;
    logic                  accept;
    logic [BIT_COUNT-1:0]  extended;

    assign offset     = addr[OFFSET_W-1:0];
    assign access_req = valid & (isLoad | isStore);
    assign misaligned = access_req & (|(offset & align_mask));
    assign accept     = (state == LSU_IDLE) & access_req & ~misaligned;

    assign memReq      = (state == LSU_BUSY);
    assign memWe       = memReq & is_store_q;
    assign stall       = accept | (state == LSU_BUSY);
    assign resultValid = (state == LSU_RESP);

    // Decode access size into an alignment mask and an unshifted strobe run.
    always_comb begin
        size_log2 = access_log2(trunc);
        if (32'(size_log2) > OFFSET_W) begin
            size_log2 = 2'(OFFSET_W);
        end
        size_bytes = 4'd1 << size_log2;
        align_mask = OFFSET_W'(size_bytes - 4'd1);
        strb_base  = STRB_W'((9'd1 << size_bytes) - 9'd1);
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP on ready, RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: if (accept)   state_next = LSU_BUSY;
            LSU_BUSY: if (memReady) state_next = LSU_RESP;
            LSU_RESP:               state_next = LSU_IDLE;
            default:                state_next = LSU_IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Register the bus request fields at accept so they stay stable while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memAddr    <= '0;
            memWdata   <= '0;
            memWstrb   <= '0;
            is_store_q <= 1'b0;
            trunc_q    <= 3'd0;
            offset_q   <= '0;
        end else if (accept) begin
            memAddr    <= {addr[BIT_COUNT-1:OFFSET_W], OFFSET_W'(0)};
            memWdata   <= storeData << {offset, 3'b000};
            memWstrb   <= strb_base << offset;
            is_store_q <= isStore;
            trunc_q    <= trunc;
            offset_q   <= offset;
        end
    end

    load_extender #(
        .BIT_COUNT (BIT_COUNT),
        .OFFSET_W  (OFFSET_W)
    ) u_load_extender (
        .rdata    (memRdata),
        .offset   (offset_q),
        .trunc    (trunc_q),
        .extended (extended)
    );

    // Capture the extended read data when memory completes; stores report 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadResult <= '0;
        end else if ((state == LSU_BUSY) && memReady) begin
            loadResult <= is_store_q ? '0 : extended;
        end
    end

endmodule
